// File: rtl/window_scanner_pkg.sv
// window_pkg: shared definitions for the window scanner slice.
//   IMG_SIZE_DEF  default input image side in pixels
//   OUT_SIZE_DEF  derived output image side (IMG_SIZE_DEF - 2)
//   PIX_W         pixel width
//   scan_state_e  scanner FSM states
//   out_size()    output side for a given image side
package window_pkg;

    localparam int unsigned IMG_SIZE_DEF = 256;
    localparam int unsigned OUT_SIZE_DEF = IMG_SIZE_DEF - 2;
    localparam int unsigned PIX_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } scan_state_e;

    function automatic int unsigned out_size(input int unsigned img_size);
        return img_size - 2;
    endfunction

endpackage

// File: rtl/window_scanner_if.sv
// window_scanner_if: window / output-stage bus of the window scanner.
//   im_addr, win_valid  window top-left address to the image RAM
//   pix_in              filter result for im_addr (combinational return)
//   out_pix, out_addr   registered output pixel and output-image address
//   out_valid/out_ready output handshake
// Modports: master = scanner side, slave = RAM/filter + output writer side.
interface window_scanner_if
    import window_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
);

    logic [ADDR_W-1:0] im_addr;
    logic              win_valid;
    logic [PIX_W-1:0]  pix_in;
    logic [PIX_W-1:0]  out_pix;
    logic [ADDR_W-1:0] out_addr;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output im_addr, win_valid, out_pix, out_addr, out_valid,
        input  pix_in, out_ready
    );

    modport slave (
        input  im_addr, win_valid, out_pix, out_addr, out_valid,
        output pix_in, out_ready
    );

endinterface

// File: rtl/window_scanner_raster_counter.sv
// raster_counter: row/column window counters with incremental address
// generation for the window scanner.
//   clk, rst     clock, asynchronous active-high reset
//   clear_i      return to window (0,0)
//   step_i       advance to the next window in row-major order
//   im_addr_o    r*IMG_SIZE + c of the current window
//   out_addr_o   r*(IMG_SIZE-2) + c of the current window
//   last_o       current window is the last one of the frame
module raster_counter
    import window_pkg::*;
#(
    parameter int unsigned IMG_SIZE = IMG_SIZE_DEF,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] im_addr_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              last_o
);

    localparam int unsigned   CW   = $clog2(IMG_SIZE);
    localparam logic [CW-1:0] LAST = CW'(IMG_SIZE - 3);

    logic [CW-1:0]     r_q, r_d, c_q, c_d;
    logic [ADDR_W-1:0] im_q, im_d, oa_q, oa_d;

    always_comb begin
        r_d  = r_q;
        c_d  = c_q;
        im_d = im_q;
        oa_d = oa_q;
        if (clear_i) begin
            r_d  = '0;
            c_d  = '0;
            im_d = '0;
            oa_d = '0;
        end else if (step_i) begin
            // Output image is dense, so its address always steps by one.
            oa_d = oa_q + ADDR_W'(1);
            if (c_q == LAST) begin
                c_d  = '0;
                r_d  = r_q + CW'(1);
                // Skip the two right-border columns to reach (r+1, 0).
                im_d = im_q + ADDR_W'(3);
            end else begin
                c_d  = c_q + CW'(1);
                im_d = im_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q  <= '0;
            c_q  <= '0;
            im_q <= '0;
            oa_q <= '0;
        end else begin
            r_q  <= r_d;
            c_q  <= c_d;
            im_q <= im_d;
            oa_q <= oa_d;
        end
    end

    assign im_addr_o  = im_q;
    assign out_addr_o = oa_q;
    assign last_o     = (r_q == LAST) && (c_q == LAST);

endmodule

// File: rtl/window_scanner.sv
// window_scanner: raster initiator for the 3x3 convolution datapath. Walks
// every valid window of an IMG_SIZE x IMG_SIZE image, registers the filter
// result into a valid/ready output stage tagged with its output address.
//   clk, rst    clock, asynchronous active-high reset
//   start       begin a frame (sampled in IDLE only)
//   busy        frame in progress (SCAN or DRAIN)
//   done        one-cycle pulse after the final output handshake
//   bus         window_scanner_if master: im_addr/win_valid/pix_in and
//               out_pix/out_addr/out_valid/out_ready
//   stall_cnt   cycles with out_valid && !out_ready (saturating); present
//               only when SCANNER_STALL_CNT_EN is defined
module window_scanner
    import window_pkg::*;
#(
    parameter int unsigned IMG_SIZE = IMG_SIZE_DEF,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    window_scanner_if.master bus
`ifdef SCANNER_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    scan_state_e       state_q;
    logic              busy_q, done_q, win_valid_q, out_valid_q;
    logic [PIX_W-1:0]  out_pix_q;
    logic [ADDR_W-1:0] out_addr_q, cnt_im_addr, cnt_out_addr;
    logic              cnt_last, launch, advance;

    assign launch  = (state_q == ST_IDLE) && start;
    // The window only moves when the output stage is empty or draining now.
    assign advance = (state_q == ST_SCAN) && (!out_valid_q || bus.out_ready);

    raster_counter #(
        .IMG_SIZE (IMG_SIZE),
        .ADDR_W   (ADDR_W)
    ) u_raster (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (launch),
        .step_i     (advance),
        .im_addr_o  (cnt_im_addr),
        .out_addr_o (cnt_out_addr),
        .last_o     (cnt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            win_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_pix_q   <= '0;
            out_addr_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_SCAN;
                        busy_q      <= 1'b1;
                        win_valid_q <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    // A capture here always refills the stage, so a same-cycle
                    // handshake leaves out_valid set with the new data.
                    if (advance) begin
                        out_pix_q   <= bus.pix_in;
                        out_addr_q  <= cnt_out_addr;
                        out_valid_q <= 1'b1;
                        if (cnt_last) begin
                            state_q     <= ST_DRAIN;
                            win_valid_q <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SCANNER_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (launch) begin
            stall_q <= '0;
        end else if (out_valid_q && !bus.out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.im_addr   = cnt_im_addr;
    assign bus.win_valid = win_valid_q;
    assign bus.out_pix   = out_pix_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_window_scanner.sv
// tb_window_scanner: directed bench for window_scanner at IMG_SIZE 4, 3 and
// 256. pix_in is derived from im_addr so each output can be traced back to
// the window that produced it.
module tb_window_scanner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start4 = 1'b0, start3 = 1'b0, start256 = 1'b0;
    logic busy4, done4, busy3, done3, busy256, done256;
`ifdef SCANNER_STALL_CNT_EN
    logic [31:0] stall4, stall3, stall256;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    window_scanner_if #(.ADDR_W(16)) if4   ();
    window_scanner_if #(.ADDR_W(16)) if3   ();
    window_scanner_if #(.ADDR_W(16)) if256 ();

    assign if4.pix_in   = if4.im_addr[7:0];
    assign if3.pix_in   = if3.im_addr[7:0] ^ 8'hA5;
    assign if256.pix_in = if256.im_addr[7:0];

    window_scanner #(.IMG_SIZE(4), .ADDR_W(16)) u_dut4 (
        .clk (clk), .rst (rst), .start (start4), .busy (busy4), .done (done4),
        .bus (if4)
`ifdef SCANNER_STALL_CNT_EN
        , .stall_cnt (stall4)
`endif
    );

    window_scanner #(.IMG_SIZE(3), .ADDR_W(16)) u_dut3 (
        .clk (clk), .rst (rst), .start (start3), .busy (busy3), .done (done3),
        .bus (if3)
`ifdef SCANNER_STALL_CNT_EN
        , .stall_cnt (stall3)
`endif
    );

    window_scanner #(.IMG_SIZE(256), .ADDR_W(16)) u_dut256 (
        .clk (clk), .rst (rst), .start (start256), .busy (busy256), .done (done256),
        .bus (if256)
`ifdef SCANNER_STALL_CNT_EN
        , .stall_cnt (stall256)
`endif
    );

    // Window top-left addresses of the 2x2 output image of a 4x4 frame.
    logic [15:0] exp_im4 [4] = '{16'd0, 16'd1, 16'd4, 16'd5};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One IMG_SIZE=4 frame with out_ready low on the cycles flagged in
    // low_mask, an optional extra start pulse, and a scoreboard of outputs.
    task automatic run4(input string nm, input logic [31:0] low_mask,
                        input int restart_cyc, input int exp_done_cyc,
                        input int exp_stall);
        int k = 0;
        int ndone = 0;
        int done_at = -1;
        start4 = 1'b1;
        if4.out_ready = 1'b1;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            tick();
            start4 = (cyc == restart_cyc);
            if4.out_ready = !low_mask[cyc];
            if (cyc == 1) begin
                check({nm, "_wv1"}, if4.win_valid, 1'b1);
                check({nm, "_im1"}, if4.im_addr, 16'd0);
            end
            if (low_mask[cyc] && if4.out_valid && k < 4) begin
                check({nm, "_hold_addr"}, if4.out_addr, k);
                check({nm, "_hold_pix"}, if4.out_pix, exp_im4[k][7:0]);
                if (if4.win_valid && k < 3)
                    check({nm, "_hold_im"}, if4.im_addr, exp_im4[k+1]);
            end
            if (if4.out_valid && if4.out_ready) begin
                if (k < 4) begin
                    check({nm, "_addr"}, if4.out_addr, k);
                    check({nm, "_pix"}, if4.out_pix, exp_im4[k][7:0]);
                end
                k++;
            end
            if (done4) begin
                ndone++;
                done_at = cyc;
            end
        end
        if4.out_ready = 1'b1;
        start4 = 1'b0;
        check({nm, "_count"}, k, 4);
        check({nm, "_ndone"}, ndone, 1);
        check({nm, "_done_cyc"}, done_at, exp_done_cyc);
        check({nm, "_busy_end"}, busy4, 1'b0);
`ifdef SCANNER_STALL_CNT_EN
        check({nm, "_stall"}, stall4, exp_stall);
`else
        if (exp_stall < 0) $display("note: negative stall expectation in %s", nm);
`endif
    endtask

    initial begin
        int k;
        int ndone;
        logic [15:0] last_im;
        logic [15:0] last_addr;
        logic [15:0] exp_im;

        if4.out_ready   = 1'b1;
        if3.out_ready   = 1'b1;
        if256.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_busy", busy4, 1'b0);
        check("rst_done", done4, 1'b0);
        check("rst_wv", if4.win_valid, 1'b0);
        check("rst_ov", if4.out_valid, 1'b0);
        check("rst_im", if4.im_addr, 16'd0);
        check("rst_oaddr", if4.out_addr, 16'd0);
        check("rst_opix", if4.out_pix, 8'd0);
`ifdef SCANNER_STALL_CNT_EN
        check("rst_stall", stall4, 32'd0);
`endif

        // 4x4 frame, out_ready held high: cycle-exact table
        start4 = 1'b1;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            tick();
            start4 = 1'b0;
            check("t1_wv", if4.win_valid, (cyc <= 4));
            if (cyc <= 4) check("t1_im", if4.im_addr, exp_im4[cyc-1]);
            check("t1_ov", if4.out_valid, (cyc >= 2 && cyc <= 5));
            if (cyc >= 2 && cyc <= 5) begin
                check("t1_oaddr", if4.out_addr, cyc - 2);
                check("t1_opix", if4.out_pix, exp_im4[cyc-2][7:0]);
            end
            check("t1_done", done4, (cyc == 6));
            check("t1_busy", busy4, (cyc <= 5));
        end

        // out_ready low on cycles 2-4
        run4("t2_stall", 32'b1_1100, 0, 9, 3);

        // start pulsed mid-scan is ignored
        run4("t3_restart", 32'd0, 2, 6, 0);

        // reset on cycle 3 of a frame
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("t4_busy", busy4, 1'b0);
        check("t4_wv", if4.win_valid, 1'b0);
        check("t4_ov", if4.out_valid, 1'b0);
        check("t4_im", if4.im_addr, 16'd0);
        check("t4_oaddr", if4.out_addr, 16'd0);
        check("t4_opix", if4.out_pix, 8'd0);
        tick();
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done4) ndone++;
        end
        check("t4_no_done", ndone, 0);
        run4("t4_rerun", 32'd0, 0, 6, 0);

        // IMG_SIZE=3: one window
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        check("t5_wv1", if3.win_valid, 1'b1);
        check("t5_im1", if3.im_addr, 16'd0);
        check("t5_busy1", busy3, 1'b1);
        check("t5_ov1", if3.out_valid, 1'b0);
        tick();
        check("t5_ov2", if3.out_valid, 1'b1);
        check("t5_oaddr2", if3.out_addr, 16'd0);
        check("t5_opix2", if3.out_pix, 8'hA5);
        check("t5_wv2", if3.win_valid, 1'b0);
        check("t5_done2", done3, 1'b0);
        tick();
        check("t5_done3", done3, 1'b1);
        check("t5_ov3", if3.out_valid, 1'b0);
        check("t5_busy3", busy3, 1'b0);
        tick();
        check("t5_done4", done3, 1'b0);

        // IMG_SIZE=256 with a mostly-ready, randomly stalling consumer
        k = 0;
        ndone = 0;
        last_im = '0;
        last_addr = '0;
        start256 = 1'b1;
        for (int cyc = 1; cyc <= 80000 && ndone == 0; cyc++) begin
            tick();
            start256 = 1'b0;
            if256.out_ready = ($urandom_range(0, 31) != 0);
            if (if256.win_valid && (!if256.out_valid || if256.out_ready))
                last_im = if256.im_addr;
            if (if256.out_valid && if256.out_ready) begin
                exp_im = 16'((k / 254) * 256 + (k % 254));
                check("t6_addr", if256.out_addr, k);
                check("t6_pix", if256.out_pix, exp_im[7:0]);
                last_addr = if256.out_addr;
                k++;
            end
            if (done256) ndone++;
        end
        if256.out_ready = 1'b1;
        check("t6_count", k, 64516);
        check("t6_last_addr", last_addr, 16'd64515);
        check("t6_last_im", last_im, 16'd65021);
        check("t6_done", ndone, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/window_scanner.md
# window_scanner

Raster initiator for the 3x3 convolution datapath. On `start` it walks the window top-left address `im_addr` over every valid window position of an IMG_SIZE x IMG_SIZE image and presents it to the image RAM, which returns the nine window pixels combinationally. It registers the filter's combinational result `pix_in` into an output stage with a valid/ready handshake, tagged with its dense output-image address. It sits between the image RAM and filter on one side and the output image writer on the other.

## Interface
- IMG_SIZE, 256: input image side in pixels; must be at least 3.
- ADDR_W, 16: width of `im_addr` and `out_addr`; 2^ADDR_W must be at least IMG_SIZE*IMG_SIZE.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  starts a frame scan; sampled only in IDLE.
- busy  out  1  high while a frame is in progress (SCAN or DRAIN).
- done  out  1  one-cycle pulse after the final output handshake.
- im_addr  out  ADDR_W  window top-left address, r*IMG_SIZE + c.
- win_valid  out  1  `im_addr` is a live window this cycle.
- pix_in  in  8  filter result for the current `im_addr`; combinational, same cycle.
- out_pix  out  8  registered filtered pixel.
- out_addr  out  ADDR_W  output address, r*(IMG_SIZE-2) + c.
- out_valid  out  1  `out_pix` and `out_addr` are valid.
- out_ready  in  1  downstream accepts the output when high together with `out_valid`.
- stall_cnt  out  32  present only under SCANNER_STALL_CNT_EN.

## Operation
- Window coordinates: r, c each run 0..IMG_SIZE-3 in row-major order, with c fastest. N = (IMG_SIZE-2)^2 windows per frame.
- FSM states: IDLE, SCAN, DRAIN, DONE.
  - IDLE -> SCAN on `start`. Clear r and c.
  - SCAN: `win_valid`=1 and `im_addr` = current window.
    - advance = !out_valid || out_ready.
    - On advance: capture `pix_in` and the output address into the output stage, set `out_valid`=1, and step c.
    - When c reaches IMG_SIZE-3, wrap c to 0 and increment r.
    - When the last window (r = c = IMG_SIZE-3) is captured, go to DRAIN.
  - DRAIN: `win_valid`=0. When out_valid && out_ready, clear `out_valid` and go to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- Output stage:
  - Holds `out_pix` and `out_addr` stable while out_valid && !out_ready.
  - Clears `out_valid` on a handshake with no new capture.
  - Never drops or duplicates an output.
- `start` outside IDLE is ignored.
- `im_addr` and `out_addr` come from incremental counters, not multipliers. The `im_addr` row step is +3 when c wraps (skipping the two border columns).
- `busy` = state is SCAN or DRAIN.

## Timing
- Reset values: state IDLE; `busy`, `done`, `win_valid`, `out_valid` are 0; `im_addr`, `out_addr`, `out_pix` are 0; `stall_cnt` is 0. Reset mid-frame aborts the frame immediately with no `done`.
- `start` high in cycle 0 (IDLE): SCAN from cycle 1 with `im_addr`=0.
- Capture latency: `pix_in` for a window appears on `out_pix` one cycle later.
- Throughput: one window per cycle while `out_ready`=1.
- With `out_ready` held 1:
  - Outputs appear on cycles 2..N+1.
  - DRAIN lasts cycle N+1.
  - `done` is high in cycle N+2; `busy` is low from cycle N+2.
- `out_ready` low in SCAN: `im_addr` holds (`win_valid` stays 1) until the output stage frees. `pix_in` must stay stable for a held address.
- A handshake and a new capture in the same cycle leave `out_valid`=1 with the new data.
- IMG_SIZE=3 gives N=1: SCAN lasts one cycle, then DRAIN.

## Configuration
- SCANNER_STALL_CNT_EN defined: `stall_cnt` port exists.
  - Counts cycles with out_valid && !out_ready.
  - Saturates at 2^32-1.
  - Clears when IDLE sees `start`.
  - Holds its value after `done`.
- SCANNER_STALL_CNT_EN undefined: port and counter absent; behaviour otherwise identical.

## Structure
- Shared package `window_pkg`:
  - Default IMG_SIZE.
  - Derived OUT_SIZE = IMG_SIZE-2.
  - Scanner state enum (IDLE, SCAN, DRAIN, DONE).
  - Pixel width constant 8.
- One sub-module, `raster_counter`: r/c counters with wrap, last-position flag, and the incremental `im_addr`/`out_addr` generation.

## Test plan
- IMG_SIZE=4, `out_ready`=1, `pix_in` = `im_addr`[7:0] -> `im_addr` 0,1,4,5 on cycles 1-4; outputs (addr,pix) = (0,0),(1,1),(2,4),(3,5) on cycles 2-5; `done` on cycle 6 only.
- IMG_SIZE=4, `out_ready` low on cycles 2-4 -> `out_pix`=0 and `out_addr`=0 held; `im_addr` holds at 1; no loss; `stall_cnt`=3 under the macro.
- `start` pulsed during SCAN -> ignored; exactly 4 outputs, one `done`.
- `rst` asserted on cycle 3 of an IMG_SIZE=4 scan -> all outputs zero immediately, no `done`; a new `start` restarts from `im_addr`=0.
- IMG_SIZE=256, random `out_ready` -> 64516 outputs; last `out_addr`=64515, paired with `im_addr`=65021; `out_addr` strictly increments by 1.
- IMG_SIZE=3 -> a single output with `out_addr`=0; `done` two cycles after the SCAN cycle.
